nes_framebuf: RTL and testbench
===============================

NES_FRAMEBUF -- requirements
Module: nes_framebuf

Interface
REQ-001 SHALL have parameter NES_WIDTH, default 256, active pixels per line.
REQ-002 SHALL have parameter NES_HEIGHT, default 240, active lines per frame.
REQ-003 SHALL have port pix_clk  input  1  sole clock (12.5 MHz); one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ppu_frame_start  input  1  single-cycle pulse marking the first pixel of a PPU frame.
REQ-006 SHALL have port ppu_valid  input  1  ppu_rgb carries a pixel in raster order.
REQ-007 SHALL have port ppu_rgb  input  9  pixel colour, 3b R/G/B.
REQ-008 SHALL have port ppu_ready  output  1  pixel accepted when ppu_valid and ppu_ready are both high.
REQ-009 SHALL have port pix_ptr_x  input  8  read column from VGA stage.
REQ-010 SHALL have port pix_ptr_y  input  8  read line from VGA stage.
REQ-011 SHALL have port vsync  input  1  VGA vsync, active low; swap timing source.
REQ-012 SHALL have port rgb_buf  output  9  front-buffer pixel at the pointer.
REQ-013 SHALL have port front_sel  output  1  index of the buffer currently displayed.
REQ-014 SHALL have port frame_drop  output  1  single-cycle pulse when a partial frame is abandoned.

Function
REQ-015 SHALL hold two NES_WIDTH x NES_HEIGHT x 9b buffers: front (read) and back (write).
REQ-016 SHALL implement write FSM states WAIT_SOF, FILL, FULL.
REQ-017 WAIT_SOF: ppu_ready=1; pixels dropped unless ppu_frame_start is high the same cycle; frame_start -> FILL with that pixel (if valid) written at address 0.
REQ-018 FILL: ppu_ready=1; each accepted pixel written at back-buffer address wr_cnt, wr_cnt increments by 1 (16b).
REQ-019 FILL: the accepted pixel at wr_cnt = NES_WIDTH*NES_HEIGHT-1 (61439) -> FULL, wr_cnt cleared.
REQ-020 FILL: ppu_frame_start before completion -> frame_drop pulse next cycle, wr_cnt restarts at 0, same-cycle valid pixel written at address 0; stays FILL.
REQ-021 FULL: ppu_ready=0; ppu_frame_start -> frame_drop pulse, state unchanged.
REQ-022 SHALL detect vsync falling edge (registered vsync 1, current vsync 0).
REQ-023 Falling edge while registered state is FULL: front_sel toggles, state -> WAIT_SOF, both next cycle.
REQ-024 Falling edge in WAIT_SOF or FILL: no swap, FSM unaffected.
REQ-025 Last pixel and vsync falling edge in the same cycle: no swap; swap at the following falling edge.
REQ-026 Read address = {pix_ptr_y, pix_ptr_x}; rgb_buf valid exactly 1 cycle after the pointer (registered RAM read).
REQ-027 pix_ptr_y >= NES_HEIGHT: rgb_buf = 0 on the following cycle.
REQ-028 Reads never target the back buffer; writes never target the front buffer.

Reset
REQ-029 rst_n low: state=WAIT_SOF, wr_cnt=0, front_sel=0, rgb_buf=0, frame_drop=0, ppu_ready=1, vsync register=1.
REQ-030 Reset mid-FILL: partial frame discarded silently, no frame_drop; RAM contents not cleared.

Structure
REQ-031 Package nes_video_pkg SHALL hold NES_WIDTH, NES_HEIGHT, the 9b rgb typedef and the FSM state enum.
REQ-032 Storage SHALL be sub-module nes_fb_ram: simple dual-port, 1 write + 1 registered read port, 17b address {buffer, y, x}, synchronous, no reset.

Verification
REQ-033 Reset, frame_start + 61440 valid pixels value = (addr mod 512), one vsync fall -> front_sel=1, pointer (x=5,y=1) gives rgb_buf=9'd261 one cycle later.
REQ-034 frame_start, 1000 pixels, frame_start again -> frame_drop one-cycle pulse, pixel with frame_start lands at address 0, full frame then completes normally.
REQ-035 Complete frame, ppu_valid held high -> ppu_ready=0 in FULL, no writes until after swap; extra frame_start -> frame_drop.
REQ-036 Last pixel coincident with vsync fall -> front_sel unchanged; toggles on the next vsync fall.
REQ-037 pix_ptr_y=240, any x -> rgb_buf=0 next cycle; pix_ptr_y=239, x=255 -> stored pixel 61439.
REQ-038 Assert rst_n low mid-FILL at wr_cnt=30000 -> all outputs at reset values asynchronously, no frame_drop, FSM in WAIT_SOF after release.

Source files
------------

// File: rtl/nes_video_pkg.sv
// -----------------------------------------------------------------------------
// nes_video_pkg
// Shared constants and types for the NES frame buffer: active picture size,
// the 9-bit RGB pixel type, frame buffer RAM address width and the write FSM
// state encoding.
// -----------------------------------------------------------------------------
package nes_video_pkg;

    localparam int NES_WIDTH  = 256;
    localparam int NES_HEIGHT = 240;

    // {buffer select, line, column}
    localparam int FB_AW = 17;

    typedef logic [8:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        FULL     = 2'd2
    } wr_state_e;

endpackage

// File: rtl/nes_fb_ram.sv
// -----------------------------------------------------------------------------
// nes_fb_ram
// Simple dual-port RAM holding both frame buffers: one synchronous write port
// and one registered read port. There is no reset, so contents survive rst_n.
//
// Ports
//   pix_clk  : clock
//   wr_en    : write strobe
//   wr_addr  : write address {buffer, y, x}
//   wr_data  : write data
//   rd_addr  : read address {buffer, y, x}
//   rd_data  : read data, one cycle after rd_addr
// -----------------------------------------------------------------------------
module nes_fb_ram #(
    parameter int AW = 17,
    parameter int DW = 9
) (
    input  logic          pix_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge pix_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/nes_framebuf.sv
// -----------------------------------------------------------------------------
// nes_framebuf
// Double-buffered frame store between the NES PPU pixel stream and the VGA
// scan-out. The PPU fills the back buffer in raster order; the buffers are
// swapped on a VGA vsync falling edge once a full frame has been captured.
//
// Ports
//   pix_clk         : sole clock
//   rst_n           : asynchronous active-low reset
//   ppu_frame_start : one-cycle pulse with the first pixel of a PPU frame
//   ppu_valid       : ppu_rgb carries a pixel
//   ppu_rgb         : 9-bit pixel (3b R/G/B)
//   ppu_ready       : pixel accepted when ppu_valid && ppu_ready
//   pix_ptr_x/y     : read pointer from the VGA stage
//   vsync           : VGA vsync (active low), swap timing
//   rgb_buf         : front-buffer pixel, one cycle after the pointer
//   front_sel       : buffer currently displayed
//   frame_drop      : one-cycle pulse when a partial frame is abandoned
//
// Write FSM
//   state    | meaning
//   WAIT_SOF | back buffer free, waiting for ppu_frame_start
//   FILL     | writing pixels into the back buffer at wr_cnt
//   FULL     | back buffer complete, waiting for vsync fall to swap
// -----------------------------------------------------------------------------
module nes_framebuf #(
    parameter int NES_WIDTH  = nes_video_pkg::NES_WIDTH,
    parameter int NES_HEIGHT = nes_video_pkg::NES_HEIGHT
) (
    input  logic       pix_clk,
    input  logic       rst_n,
    input  logic       ppu_frame_start,
    input  logic       ppu_valid,
    input  logic [8:0] ppu_rgb,
    output logic       ppu_ready,
    input  logic [7:0] pix_ptr_x,
    input  logic [7:0] pix_ptr_y,
    input  logic       vsync,
    output logic [8:0] rgb_buf,
    output logic       front_sel,
    output logic       frame_drop
);

    import nes_video_pkg::*;

    localparam logic [15:0] LAST_ADDR = 16'(NES_WIDTH * NES_HEIGHT - 1);
    localparam logic [8:0]  HEIGHT9   = 9'(NES_HEIGHT);

    wr_state_e   state_q, state_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        front_sel_q, front_sel_d;
    logic        frame_drop_q, frame_drop_d;
    logic        vsync_q;
    logic        rd_en_q, rd_en_d;

    logic        vsync_fall;
    logic        wr_en;
    logic [15:0] wr_addr_lo;
    rgb_t        rd_data;

    assign vsync_fall = vsync_q & ~vsync;

    // Out-of-range lines read as black; the flag also masks the un-reset RAM
    // output so rgb_buf is 0 while in reset.
    assign rd_en_d = ({1'b0, pix_ptr_y} < HEIGHT9);

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        front_sel_d  = front_sel_q;
        frame_drop_d = 1'b0;
        wr_en        = 1'b0;
        wr_addr_lo   = wr_cnt_q;
        ppu_ready    = 1'b1;

        case (state_q)
            WAIT_SOF: begin
                if (ppu_frame_start) begin
                    state_d    = FILL;
                    wr_addr_lo = '0;
                    wr_en      = ppu_valid;
                    wr_cnt_d   = ppu_valid ? 16'd1 : 16'd0;
                end
            end
            FILL: begin
                if (ppu_frame_start) begin
                    // Restart the frame; the pixel carrying the pulse is pixel 0.
                    frame_drop_d = 1'b1;
                    wr_addr_lo   = '0;
                    wr_en        = ppu_valid;
                    wr_cnt_d     = ppu_valid ? 16'd1 : 16'd0;
                end else if (ppu_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d  = FULL;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end
                end
            end
            FULL: begin
                ppu_ready    = 1'b0;
                frame_drop_d = ppu_frame_start;
                // Only a registered FULL swaps, so a last pixel coinciding with
                // the vsync fall waits for the next fall.
                if (vsync_fall) begin
                    state_d     = WAIT_SOF;
                    front_sel_d = ~front_sel_q;
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_SOF;
            wr_cnt_q     <= '0;
            front_sel_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            vsync_q      <= 1'b1;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            front_sel_q  <= front_sel_d;
            frame_drop_q <= frame_drop_d;
            vsync_q      <= vsync;
            rd_en_q      <= rd_en_d;
        end
    end

    // With a 256-pixel line the linear write count equals {y, x}, so reads
    // and writes share one address layout.
    nes_fb_ram #(
        .AW (FB_AW),
        .DW (9)
    ) u_ram (
        .pix_clk (pix_clk),
        .wr_en   (wr_en),
        .wr_addr ({~front_sel_q, wr_addr_lo}),
        .wr_data (ppu_rgb),
        .rd_addr ({front_sel_q, pix_ptr_y, pix_ptr_x}),
        .rd_data (rd_data)
    );

    assign rgb_buf    = rd_en_q ? rd_data : 9'd0;
    assign front_sel  = front_sel_q;
    assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_nes_framebuf.sv
// -----------------------------------------------------------------------------
// tb_nes_framebuf
// Self-checking bench for nes_framebuf. The frame height is reduced to 12 lines
// so several complete frames fit in a short run; the line width stays 256 so
// the {y, x} address layout is unchanged.
// -----------------------------------------------------------------------------
module tb_nes_framebuf;

    localparam int W = 256;
    localparam int H = 12;
    localparam int N = W * H;

    logic       pix_clk = 1'b0;
    logic       rst_n;
    logic       ppu_frame_start;
    logic       ppu_valid;
    logic [8:0] ppu_rgb;
    logic       ppu_ready;
    logic [7:0] pix_ptr_x;
    logic [7:0] pix_ptr_y;
    logic       vsync;
    logic [8:0] rgb_buf;
    logic       front_sel;
    logic       frame_drop;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    bit rand_ptr = 1'b0;

    always #5 pix_clk = ~pix_clk;

    nes_framebuf #(
        .NES_WIDTH  (W),
        .NES_HEIGHT (H)
    ) dut (
        .pix_clk         (pix_clk),
        .rst_n           (rst_n),
        .ppu_frame_start (ppu_frame_start),
        .ppu_valid       (ppu_valid),
        .ppu_rgb         (ppu_rgb),
        .ppu_ready       (ppu_ready),
        .pix_ptr_x       (pix_ptr_x),
        .pix_ptr_y       (pix_ptr_y),
        .vsync           (vsync),
        .rgb_buf         (rgb_buf),
        .front_sel       (front_sel),
        .frame_drop      (frame_drop)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: two picture arrays, which one is shown, and where
    // the incoming frame stands (0 = waiting, 1 = filling, 2 = complete).
    // ------------------------------------------------------------------
    logic [8:0] mbuf   [0:1][0:65535];
    bit         mknown [0:1][0:65535];
    int         m_phase;
    int         m_cnt;
    bit         m_front;
    bit         m_drop;
    logic [8:0] m_rgb;
    bit         m_known;
    bit         m_vs;
    bit         m_fall;
    int         m_addr;

    task automatic m_write(input int a, input logic [8:0] v);
        mbuf[!m_front][a]   = v;
        mknown[!m_front][a] = 1'b1;
    endtask

    always @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_front = 1'b0;
            m_drop  = 1'b0;
            m_rgb   = 9'd0;
            m_known = 1'b1;
            m_vs    = 1'b1;
        end else begin
            m_fall = m_vs && !vsync;
            m_vs   = vsync;
            m_drop = 1'b0;
            if (int'(pix_ptr_y) < H) begin
                m_addr  = int'(pix_ptr_y) * W + int'(pix_ptr_x);
                m_rgb   = mbuf[m_front][m_addr];
                m_known = mknown[m_front][m_addr];
            end else begin
                m_rgb   = 9'd0;
                m_known = 1'b1;
            end
            if (m_phase == 2) begin
                if (ppu_frame_start) m_drop = 1'b1;
                if (m_fall) begin
                    m_front = !m_front;
                    m_phase = 0;
                end
            end else if (ppu_frame_start) begin
                if (m_phase == 1) m_drop = 1'b1;
                m_phase = 1;
                m_cnt   = 0;
                if (ppu_valid) begin
                    m_write(0, ppu_rgb);
                    m_cnt = 1;
                end
            end else if (m_phase == 1 && ppu_valid) begin
                m_write(m_cnt, ppu_rgb);
                m_cnt++;
                if (m_cnt == N) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end
            end
        end
    end

    always @(negedge pix_clk) begin
        if (chk_on) begin
            chk("ready", int'(ppu_ready), (m_phase != 2) ? 1 : 0);
            chk("front_sel", int'(front_sel), int'(m_front));
            chk("frame_drop", int'(frame_drop), int'(m_drop));
            if (m_known) chk("rgb_buf", int'(rgb_buf), int'(m_rgb));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge pix_clk);
        #2;
        if (rand_ptr) begin
            pix_ptr_x = 8'($urandom_range(0, 255));
            pix_ptr_y = 8'($urandom_range(0, H + 3));
        end
    endtask

    task automatic sample();
        @(negedge pix_clk);
    endtask

    task automatic send_pix(input logic [8:0] v, input bit fs);
        ppu_valid       = 1'b1;
        ppu_rgb         = v;
        ppu_frame_start = fs;
        tick();
        ppu_valid       = 1'b0;
        ppu_frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_fall();
        vsync = 1'b0;
        idle(4);
        vsync = 1'b1;
        idle(2);
    endtask

    task automatic sweep();
        bit save;
        save = rand_ptr;
        rand_ptr = 1'b0;
        for (int a = 0; a < N; a++) begin
            pix_ptr_y = 8'(a / W);
            pix_ptr_x = 8'(a % W);
            tick();
        end
        tick();
        rand_ptr = save;
    endtask

    task automatic full_frame_random();
        for (int i = 0; i < N; i++) send_pix(9'($urandom), i == 0);
    endtask

    logic [8:0] v0;

    initial begin
        rst_n = 1'b0;
        ppu_frame_start = 1'b0;
        ppu_valid = 1'b0;
        ppu_rgb = 9'd0;
        pix_ptr_x = 8'd0;
        pix_ptr_y = 8'd0;
        vsync = 1'b1;
        repeat (3) @(posedge pix_clk);
        #2;
        chk_on = 1'b1;
        sample();
        chk("rst_ready", int'(ppu_ready), 1);
        chk("rst_front", int'(front_sel), 0);
        chk("rst_drop", int'(frame_drop), 0);
        chk("rst_rgb", int'(rgb_buf), 0);
        tick();
        rst_n = 1'b1;
        idle(3);

        // Frame of addr mod 512, then swap and pinned reads.
        for (int i = 0; i < N; i++) send_pix(9'(i % 512), i == 0);
        sample();
        chk("t1_full_ready", int'(ppu_ready), 0);
        idle(3);
        vsync = 1'b0;
        tick();
        sample();
        chk("t1_swap_front", int'(front_sel), 1);
        idle(3);
        vsync = 1'b1;
        idle(2);
        pix_ptr_x = 8'd5;
        pix_ptr_y = 8'd1;
        tick();
        sample();
        chk("t1_pix_5_1", int'(rgb_buf), 261);
        pix_ptr_x = 8'($urandom);
        pix_ptr_y = 8'(H);
        tick();
        sample();
        chk("t1_oor_line", int'(rgb_buf), 0);
        pix_ptr_x = 8'd255;
        pix_ptr_y = 8'(H - 1);
        tick();
        sample();
        chk("t1_last_pix", int'(rgb_buf), 511);
        sweep();

        // Abandoned frame: restart after 1000 pixels.
        rand_ptr = 1'b1;
        for (int i = 0; i < 1000; i++) send_pix(9'($urandom), i == 0);
        v0 = 9'($urandom);
        send_pix(v0, 1'b1);
        sample();
        chk("t2_drop_pulse", int'(frame_drop), 1);
        tick();
        sample();
        chk("t2_drop_single", int'(frame_drop), 0);
        for (int sent = 1; sent < N; ) begin
            if ($urandom_range(0, 3) != 0) begin
                send_pix(9'($urandom), 1'b0);
                sent++;
            end else begin
                tick();
            end
        end
        idle(2);
        vs_fall();
        sample();
        chk("t2_front", int'(front_sel), 0);
        rand_ptr = 1'b0;
        pix_ptr_x = 8'd0;
        pix_ptr_y = 8'd0;
        tick();
        sample();
        chk("t2_addr0", int'(rgb_buf), int'(v0));
        sweep();

        // Valid held high through FULL, extra frame_start, swap.
        rand_ptr = 1'b1;
        full_frame_random();
        for (int i = 0; i < 40; i++) begin
            send_pix(9'($urandom), i == 10);
            if (i == 10) begin
                sample();
                chk("t3_full_drop", int'(frame_drop), 1);
                chk("t3_full_ready", int'(ppu_ready), 0);
            end
        end
        vsync = 1'b0;
        for (int i = 0; i < 8; i++) send_pix(9'($urandom), 1'b0);
        vsync = 1'b1;
        for (int i = 0; i < 8; i++) send_pix(9'($urandom), 1'b0);
        sample();
        chk("t3_front", int'(front_sel), 1);
        sweep();

        // Last pixel coincident with vsync fall.
        for (int i = 0; i < N - 1; i++) send_pix(9'($urandom), i == 0);
        vsync = 1'b0;
        send_pix(9'($urandom), 1'b0);
        sample();
        chk("t4_no_swap", int'(front_sel), 1);
        idle(3);
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        tick();
        sample();
        chk("t4_late_swap", int'(front_sel), 0);
        vsync = 1'b1;
        idle(2);

        // Swap once more so reset visibly clears front_sel, then reset mid-fill.
        full_frame_random();
        vs_fall();
        for (int i = 0; i < N / 2; i++) send_pix(9'($urandom), i == 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", int'(ppu_ready), 1);
        chk("t5_rst_front", int'(front_sel), 0);
        chk("t5_rst_drop", int'(frame_drop), 0);
        chk("t5_rst_rgb", int'(rgb_buf), 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) send_pix(9'($urandom), 1'b0);
        sample();
        chk("t5_wait_sof_ready", int'(ppu_ready), 1);
        tick();

        // Random traffic.
        for (int cyc = 0; cyc < 20000; cyc++) begin
            ppu_valid       = ($urandom_range(0, 7) != 0);
            ppu_rgb         = 9'($urandom);
            ppu_frame_start = ($urandom_range(0, 2999) == 0);
            vsync           = ((cyc % 700) >= 20);
            tick();
        end
        ppu_valid = 1'b0;
        ppu_frame_start = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
